dif_pair_feed: RTL

//  Input commutator for one radix-2 DIF stage. Accepts a serial complex stream, one sample per valid.

---
 rtl/dif_pair_feed.sv | 105 ++++++++++
 1 files changed

// File: rtl/dif_pair_feed.sv
// Input commutator for one radix-2 DIF stage: buffers the first half of each
// frame and presents (x[k], x[k+HALF]) to the butterfly during the second half.
module dif_pair_feed #(
  parameter int W            = 10,
  parameter int STAGE        = 0,
  parameter int TOTAL_STAGES = 8
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_init,
  input  logic         i_vld,
  input  logic [W-1:0] i_I,
  input  logic [W-1:0] i_Q,
  output logic         o_vld,
  output logic [W-1:0] o_LI,
  output logic [W-1:0] o_LQ,
  output logic [W-1:0] o_RI,
  output logic [W-1:0] o_RQ,
  output logic         o_first
);

  localparam int CW = TOTAL_STAGES - STAGE;      // log2(STAGE_FFT_LEN)
  localparam int AW = (CW > 1) ? CW - 1 : 1;

  logic [CW-1:0]  cnt;
  logic [AW-1:0]  addr;
  logic           init_r;
  logic           flush;
  logic           acc;
  logic           pair_phase;
  logic [2*W-1:0] mem [2**AW];
  logic [2*W-1:0] rd_data;
  logic [2*W-1:0] live;
  logic           rd_vld;
  logic           rd_first;

  generate
    if (CW > 1) begin : g_addr
      assign addr = cnt[CW-2:0];
    end else begin : g_addr_const
      assign addr = '0;
    end
  endgenerate

  // A sample arriving while i_init is high, or one cycle after, is dropped.
  assign flush      = i_init | init_r;
  assign acc        = i_vld & ~flush;
  assign pair_phase = cnt[CW-1];

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_r   <= 1'b0;
      cnt      <= '0;
      rd_vld   <= 1'b0;
      rd_first <= 1'b0;
      o_vld    <= 1'b0;
      o_first  <= 1'b0;
    end else begin
      init_r <= i_init;
      if (flush) begin
        cnt      <= '0;
        rd_vld   <= 1'b0;
        rd_first <= 1'b0;
        o_vld    <= 1'b0;
        o_first  <= 1'b0;
      end else begin
        if (i_vld) cnt <= cnt + 1'b1;
        rd_vld   <= i_vld & pair_phase;
        rd_first <= i_vld & pair_phase & (addr == '0);
        o_vld    <= rd_vld;
        o_first  <= rd_first;
      end
    end
  end

  // NOTE: the sample buffer has no reset; FILL always rewrites an entry before
  // PAIR reads it, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (acc && !pair_phase) mem[addr] <= {i_I, i_Q};
  end

  // Buffer read and live-sample delay share one stage so both halves line up.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data <= '0;
      live    <= '0;
      o_LI    <= '0;
      o_LQ    <= '0;
      o_RI    <= '0;
      o_RQ    <= '0;
    end else begin
      if (acc && pair_phase) begin
        rd_data <= mem[addr];
        live    <= {i_I, i_Q};
      end
      if (rd_vld && !flush) begin
        {o_LI, o_LQ} <= rd_data;
        {o_RI, o_RQ} <= live;
      end
    end
  end

endmodule
